// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential single-precision style floating-point divider, quotient = a / b.
// Restoring radix-2 mantissa division producing one quotient bit per clock.
// Number model: hidden bit always 1, no denormal/NaN/Inf inputs, truncating rounding,
// exponent arithmetic wraps modulo 2^EXP_W with no over/underflow flags.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid
//   in_ready   divider idle and able to accept operands
//   a, b       dividend / divisor {sign, exp, man}
//   out_valid  quotient valid
//   out_ready  consumer accepts quotient
//   quotient   result {sign, exp, man}
//   div_zero   divisor magnitude was zero; qualified by out_valid
module fp_div_seq #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned BIAS  = 127
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   quotient,
    output logic                   div_zero
);

    localparam int unsigned QW = MAN_W + 2;          // quotient / remainder width
    localparam int unsigned CW = $clog2(MAN_W + 2);  // iteration counter width
    localparam logic [EXP_W-1:0] BiasW = EXP_W'(BIAS);
    localparam logic [CW-1:0]    CntInit = CW'(MAN_W + 1);

    typedef enum logic [1:0] {StIdle, StDiv, StNorm, StDone} state_e;

    state_e                 state_q, state_d;
    logic                   sq_q, sq_d;
    logic [EXP_W-1:0]       ea_q, ea_d;
    logic [EXP_W-1:0]       eb_q, eb_d;
    logic [MAN_W:0]         mb_q, mb_d;
    logic [QW-1:0]          rem_q, rem_d;
    logic [QW-1:0]          q_q, q_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [EXP_W+MAN_W:0]   quot_q, quot_d;
    logic                   dz_q, dz_d;

    logic                   rem_ge;
    logic [QW-1:0]          rem_sub;
    logic [EXP_W-1:0]       exp_base;
    logic [EXP_W-1:0]       exp_norm;
    logic [MAN_W-1:0]       man_norm;

    // Remainder stays below 2*mb, so QW bits hold it and the divisor zero-extends by one bit.
    assign rem_ge   = rem_q >= {1'b0, mb_q};
    assign rem_sub  = rem_q - {1'b0, mb_q};
    assign exp_base = ea_q - eb_q + BiasW;

    // Quotient MSB has weight 2^0: if clear, the result lies in [0.5,1) and needs one shift.
    always_comb begin
        if (q_q[QW-1]) begin
            man_norm = q_q[MAN_W:1];
            exp_norm = exp_base;
        end else begin
            man_norm = q_q[MAN_W-1:0];
            exp_norm = exp_base - EXP_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        sq_d    = sq_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        mb_d    = mb_q;
        rem_d   = rem_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        dz_d    = dz_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sq_d  = a[EXP_W+MAN_W] ^ b[EXP_W+MAN_W];
                    ea_d  = a[EXP_W+MAN_W-1:MAN_W];
                    eb_d  = b[EXP_W+MAN_W-1:MAN_W];
                    mb_d  = {1'b1, b[MAN_W-1:0]};
                    rem_d = {2'b01, a[MAN_W-1:0]};
                    q_d   = '0;
                    cnt_d = CntInit;
                    if (b[EXP_W+MAN_W-1:0] == '0) begin
                        quot_d  = {a[EXP_W+MAN_W] ^ b[EXP_W+MAN_W], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        dz_d    = 1'b1;
                        state_d = StDone;
                    end else if (a[EXP_W+MAN_W-1:0] == '0) begin
                        quot_d  = {a[EXP_W+MAN_W] ^ b[EXP_W+MAN_W], {(EXP_W+MAN_W){1'b0}}};
                        dz_d    = 1'b0;
                        state_d = StDone;
                    end else begin
                        state_d = StDiv;
                    end
                end
            end
            StDiv: begin
                q_d = {q_q[QW-2:0], rem_ge};
                if (rem_ge) begin
                    rem_d = {rem_sub[QW-2:0], 1'b0};
                end else begin
                    rem_d = {rem_q[QW-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = StNorm;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StNorm: begin
                quot_d  = {sq_q, exp_norm, man_norm};
                dz_d    = 1'b0;
                state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sq_q    <= 1'b0;
            ea_q    <= '0;
            eb_q    <= '0;
            mb_q    <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sq_q    <= sq_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            mb_q    <= mb_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            dz_q    <= dz_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign quotient  = quot_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: self-checking bench for fp_div_seq (EXP_W=8, MAN_W=23, BIAS=127).
// Directed cases plus randomized operands with random backpressure, checked against an
// integer-division reference model.
module tb_fp_div_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic        div_zero;

    int n_tests;
    int n_fail;

    fp_div_seq #(
        .EXP_W(8),
        .MAN_W(23),
        .BIAS (127)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quotient (quotient),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {div_zero, quotient}; mantissa quotient is floor(ma * 2^24 / mb).
    function automatic logic [32:0] ref_div(input logic [31:0] av, input logic [31:0] bv);
        logic             sq;
        longint unsigned  ma, mb, quo;
        int               e;
        logic [22:0]      man;
        sq = av[31] ^ bv[31];
        if (bv[30:0] == 31'd0) return {1'b1, sq, 8'hFF, 23'd0};
        if (av[30:0] == 31'd0) return {1'b0, sq, 31'd0};
        ma  = 64'(av[22:0]) + (64'd1 << 23);
        mb  = 64'(bv[22:0]) + (64'd1 << 23);
        quo = (ma << 24) / mb;
        if (quo >= (64'd1 << 24)) begin
            man = 23'((quo >> 1) & 64'h7FFFFF);
            e   = int'(av[30:23]) - int'(bv[30:23]) + 127;
        end else begin
            man = 23'(quo & 64'h7FFFFF);
            e   = int'(av[30:23]) - int'(bv[30:23]) + 126;
        end
        return {1'b0, sq, 8'(e & 255), man};
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        v = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
        if ($urandom_range(0, 9) == 0) v[30:0] = 31'd0;
        return v;
    endfunction

    // Called at a negedge with the DUT idle. Junk operands are driven with in_valid high
    // while busy; they must be ignored.
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input int hold);
        logic [32:0] r;
        int          n;
        int          exp_lat;
        r = ref_div(av, bv);
        exp_lat = (av[30:0] == 31'd0 || bv[30:0] == 31'd0) ? 0 : 26;
        check_eq("in_ready_idle", 64'(in_ready), 64'd1);
        a = av; b = bv; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a = $urandom; b = $urandom;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            a = $urandom; b = $urandom;
        end
        check_eq("latency", 64'(n), 64'(exp_lat));
        check_eq("quotient", 64'(quotient), 64'(r[31:0]));
        check_eq("div_zero", 64'(div_zero), 64'(r[32]));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            a = $urandom; b = $urandom;
            check_eq("hold_valid", 64'(out_valid), 64'd1);
            check_eq("hold_in_ready", 64'(in_ready), 64'd0);
            check_eq("hold_quotient", 64'(quotient), 64'(r[31:0]));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("post_hs_valid", 64'(out_valid), 64'd0);
        check_eq("post_hs_quotient", 64'(quotient), 64'(r[31:0]));
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_quotient", 64'(quotient), 64'd0);
        check_eq("rst_div_zero", 64'(div_zero), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(32'h40C00000, 32'h40000000, 0);   // 6/2
        do_op(32'h3F800000, 32'h40400000, 1);   // 1/3
        do_op(32'hBF800000, 32'h40000000, 0);   // -1/2
        do_op(32'h3F800000, 32'h00000000, 0);   // 1/0
        do_op(32'hBF800000, 32'h80000000, 0);   // -1/-0
        do_op(32'h00000000, 32'h40A00000, 0);   // 0/5
        do_op(32'h40C00000, 32'h40000000, 10);  // backpressure

        // Reset asserted mid-division takes effect without a clock edge.
        a = 32'h40C00000; b = 32'h40400000; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("mid_rst_quotient", 64'(quotient), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(32'h40C00000, 32'h40400000, 0);   // 6/3 after reset

        for (int k = 0; k < 40; k++) begin
            do_op(rand_operand(), rand_operand(), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
